// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES-128 key expansion with an external S-box.
// Emits one 16-byte round key per round_complete request.
module key_expand_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter int SBOX_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_din,
    input  logic [7:0] din,
    input  logic [7:0] sbox_in,
    input  logic       round_complete,
    output logic [7:0] addr_out,
    output logic       enable_sbox,
    output logic [7:0] dout,
    output logic       enable_out,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, LOAD, SUB, MIX, WAIT, OUT, DONE} state_t;
    localparam logic [3:0] LAT = 4'(SBOX_LAT);
    localparam logic [3:0] NR  = 4'(NUM_ROUNDS);

    state_t     r_state, w_next;
    logic [3:0] r_cnt, r_n, r_round;
    logic [7:0] r_rcon, r_dout;
    logic [7:0] r_key [16];
    logic [7:0] r_new [16];
    logic [7:0] r_t   [4];
    logic [7:0] w_col [4];
    logic [1:0] w_tidx, w_arow;
    logic       w_load, w_more;

    assign w_load = (r_state == IDLE || r_state == LOAD || r_state == DONE) && enable_din;
    assign w_more = r_round < NR;
    assign w_tidx = r_cnt[1:0] - LAT[1:0];
    assign w_arow = r_cnt[1:0] + 2'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, LOAD, DONE: if (enable_din) w_next = (r_n == 4'd15) ? SUB : LOAD;
            SUB:     if (r_cnt == 4'd3 + LAT) w_next = MIX;
            MIX:     if (r_cnt == 4'd3) w_next = WAIT;
            WAIT:    if (round_complete) w_next = OUT;
            OUT:     if (r_cnt == 4'd15) w_next = w_more ? SUB : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Column 0 folds in the substituted, rotated last word; later columns chain.
    always_comb begin
        for (int r = 0; r < 4; r++)
            w_col[r] = r_key[{2'(r), r_cnt[1:0]}] ^ ((r_cnt[1:0] == 2'd0)
                     ? (r_t[r] ^ ((r == 0) ? r_rcon : 8'h00))
                     : r_new[{2'(r), r_cnt[1:0] - 2'd1}]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n     <= '0;
            r_round <= '0;
            r_rcon  <= 8'h01;
            r_dout  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_key[i] <= '0;
                r_new[i] <= '0;
            end
            for (int i = 0; i < 4; i++) r_t[i] <= '0;
        end else begin
            if (w_load) begin
                r_key[r_n] <= din;
                r_n        <= r_n + 4'd1;
                if (r_n == 4'd15) begin
                    r_round <= 4'd1;
                    r_rcon  <= 8'h01;
                end
            end
            if (r_state == SUB && r_cnt >= LAT) r_t[w_tidx] <= sbox_in;
            if (r_state == MIX)
                for (int r = 0; r < 4; r++) r_new[{2'(r), r_cnt[1:0]}] <= w_col[r];
            if (r_state == OUT) begin
                r_dout <= r_new[r_cnt];
                if (r_cnt == 4'd15 && w_more) begin
                    for (int i = 0; i < 16; i++) r_key[i] <= r_new[i];
                    r_round <= r_round + 4'd1;
                    r_rcon  <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
            end
        end
    end

    assign enable_sbox = r_state == SUB && r_cnt < 4'd4;
    assign addr_out    = enable_sbox ? r_key[{w_arow, 2'b11}] : 8'h00;
    assign enable_out  = r_state == OUT;
    assign dout        = enable_out ? r_new[r_cnt] : r_dout;
    assign busy        = r_state == SUB || r_state == MIX;
    assign done        = r_state == DONE;
    assign round_idx   = r_round;
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: directed FIPS-197 vectors on a default instance and a
// SBOX_LAT=3 / NUM_ROUNDS=1 instance, with a behavioural S-box.
module tb_key_expand_seq;
    localparam logic [127:0] KEY = 128'h2b28ab097eaef7cf15d2154f16a6883c;
    localparam logic [127:0] R1  = 128'ha088232afa54a36cfe2c397617b13905;
    localparam logic [127:0] R10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
    localparam logic [2047:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk, rst;
    logic en_a, rc_a, es_a, eo_a, busy_a, done_a;
    logic en_b, rc_b, es_b, eo_b, busy_b, done_b;
    logic [7:0] din_a, sb_a, addr_a, do_a, din_b, sb_b, addr_b, do_b, pa;
    logic [7:0] pb [3];
    logic [3:0] ri_a, ri_b;
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int n_chk = 0, n_pass = 0, base;
    int sp_a = 0, run_a = 0, last_a = 0, sp_b = 0, run_b = 0, last_b = 0;

    key_expand_seq dut_a (
        .clk(clk), .rst(rst), .enable_din(en_a), .din(din_a), .sbox_in(sb_a),
        .round_complete(rc_a), .addr_out(addr_a), .enable_sbox(es_a), .dout(do_a),
        .enable_out(eo_a), .round_idx(ri_a), .busy(busy_a), .done(done_a));

    key_expand_seq #(.NUM_ROUNDS(1), .SBOX_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .enable_din(en_b), .din(din_b), .sbox_in(sb_b),
        .round_complete(rc_b), .addr_out(addr_b), .enable_sbox(es_b), .dout(do_b),
        .enable_out(eo_b), .round_idx(ri_b), .busy(busy_b), .done(done_b));

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SB[(255 - int'(a)) * 8 +: 8];
    endfunction

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pa    <= sbox(addr_a);
        pb[0] <= sbox(addr_b);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign sb_a = pa;
    assign sb_b = pb[2];

    always @(negedge clk) begin
        if (eo_a) qa.push_back(do_a);
        if (es_a) sp_a <= sp_a + 1;
        if (busy_a) run_a <= run_a + 1;
        else if (run_a != 0) begin
            last_a <= run_a;
            run_a  <= 0;
        end
        if (eo_b) qb.push_back(do_b);
        if (es_b) sp_b <= sp_b + 1;
        if (busy_b) run_b <= run_b + 1;
        else if (run_b != 0) begin
            last_b <= run_b;
            run_b  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit b, input int gap);
        for (int i = 0; i < 16; i++) begin
            if (b) begin
                en_b  = 1;
                din_b = KEY[127 - 8 * i -: 8];
            end else begin
                en_a  = 1;
                din_a = KEY[127 - 8 * i -: 8];
            end
            tick;
            en_a = 0;
            en_b = 0;
            repeat (gap) tick;
        end
    endtask

    task automatic check_round(input string tag, input bit b, input int at, input logic [127:0] exp);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_byte%0d", tag, i), b ? qb[at + i] : qa[at + i], exp[127 - 8 * i -: 8]);
    endtask

    initial begin
        rst = 1; en_a = 0; en_b = 0; din_a = 0; din_b = 0; rc_a = 0; rc_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable_out", eo_a, 0);
        check("rst_enable_sbox", es_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_dout", do_a, 0);
        check("rst_addr_out", addr_a, 0);
        check("rst_round_idx", ri_a, 0);
        rst = 0;
        tick;
        check("idle_busy", busy_a, 0);

        rc_b = 1;
        load(1, 1);
        for (int i = 0; i < 600 && !done_b; i++) tick;
        check("b_done", done_b, 1);
        check("b_out_count", qb.size(), 16);
        check_round("b_r1", 1, 0, R1);
        check("b_busy_cycles", last_b, 11);
        check("b_sbox_pulses", sp_b, 4);
        check("b_round_idx", ri_b, 1);
        en_b = 1;
        din_b = 8'h55;
        tick;
        en_b = 0;
        check("b_reload_clears_done", done_b, 0);

        rc_a = 1;
        load(0, 0);
        for (int i = 0; i < 1000 && !done_a; i++) tick;
        check("a_done", done_a, 1);
        check("a_round_idx_final", ri_a, 10);
        check("a_out_count", qa.size(), 160);
        check_round("a_r1", 0, 0, R1);
        check_round("a_r10", 0, 144, R10);
        check("a_busy_cycles", last_a, 9);
        check("a_sbox_pulses", sp_a, 40);

        rc_a = 0;
        base = qa.size();
        load(0, 0);
        check("a_reload_done", done_a, 0);
        check("a_reload_busy", busy_a, 1);
        tick;
        tick;
        rc_a = 1;
        tick;
        rc_a = 0;
        repeat (60) tick;
        check("a_hold_no_out", qa.size() - base, 0);
        check("a_hold_enable_out", eo_a, 0);
        check("a_hold_round_idx", ri_a, 1);
        rc_a = 1;
        tick;
        check("a_out_start", eo_a, 1);
        rc_a = 0;
        repeat (30) tick;
        check("a_pulse_count", qa.size() - base, 16);
        check_round("a_pulse_r1", 0, base, R1);

        base = qa.size();
        rc_a = 1;
        for (int i = 0; i < 400 && qa.size() - base < 23; i++) tick;
        check("a_mid_stream", eo_a, 1);
        check("a_mid_round_idx", ri_a, 3);
        #2 rst = 1;
        #1;
        check("a_abort_enable_out", eo_a, 0);
        check("a_abort_round_idx", ri_a, 0);
        check("a_abort_dout", do_a, 0);
        tick;
        rst = 0;
        tick;
        base = qa.size();
        load(0, 0);
        for (int i = 0; i < 100 && !eo_a; i++) tick;
        check("a_restart_stream", eo_a, 1);
        check("a_restart_round_idx", ri_a, 1);
        for (int i = 0; i < 100 && qa.size() - base < 16; i++) tick;
        check_round("a_restart_r1", 0, base, R1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
